ir_packet_encoder: RTL and testbench

- Downstream stage of the IR transmitter bus-command register and its 10 Hz packet trigger.
- On each accepted SEND_PACKET pulse it latches the 4-bit car COMMAND and serialises it as a pulse-coded IR packet on a modulated carrier, driving IR_LED directly.
- Segment lengths and the carrier are parameterised, so one RTL covers every car colour coding.

---
 rtl/ir_packet_encoder.sv | 153 +++++++++++++++
 tb/tb_ir_packet_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_encoder.sv
// rtl/ir_packet_encoder.sv - serialises a latched 4-bit car command as a pulse-coded IR packet on a modulated carrier
module ir_packet_encoder #(
    parameter int CARRIER_PERIOD = 2778,
    parameter int CARRIER_HIGH   = 1389,
    parameter int START_LEN      = 191,
    parameter int GAP_LEN        = 25,
    parameter int CARSEL_LEN     = 47,
    parameter int ASSERT_LEN     = 47,
    parameter int DEASSERT_LEN   = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COMMAND,
    input  logic       SEND_PACKET,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PACKET_DONE
);

    // Longest segment decides the period counter width; pc never exceeds len-1.
    localparam int MAX_SG = (START_LEN > GAP_LEN) ? START_LEN : GAP_LEN;
    localparam int MAX_CA = (CARSEL_LEN > ASSERT_LEN) ? CARSEL_LEN : ASSERT_LEN;
    localparam int MAX_AB = (MAX_SG > MAX_CA) ? MAX_SG : MAX_CA;
    localparam int MAX_LEN = (MAX_AB > DEASSERT_LEN) ? MAX_AB : DEASSERT_LEN;
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

    localparam logic [CW-1:0] CC_LAST = CW'(CARRIER_PERIOD - 1);
    // IR_LED value for the first clock (cc = 0) of a burst period.
    localparam logic BURST0 = (CARRIER_HIGH > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_CARSEL,
        S_BIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cc;
    logic [PW-1:0]   pc;
    logic [3:0]      cmd_q;
    logic [1:0]      idx;
    logic            after_bits;   // current GAP follows a BIT segment
    logic            carsel_sent;  // CARSEL already transmitted in this packet
    logic [PW-1:0]   seg_last;
    logic            in_burst;

    // Last period index of the current segment.
    always_comb begin
        seg_last = PW'(GAP_LEN - 1);
        case (state)
            S_START:  seg_last = PW'(START_LEN - 1);
            S_CARSEL: seg_last = PW'(CARSEL_LEN - 1);
            S_BIT:    seg_last = cmd_q[idx] ? PW'(ASSERT_LEN - 1) : PW'(DEASSERT_LEN - 1);
            default:  seg_last = PW'(GAP_LEN - 1);
        endcase
    end

    // Carrier is only driven during burst segments.
    always_comb begin
        in_burst = (state == S_START) || (state == S_CARSEL) || (state == S_BIT);
    end

    // Packet sequencer: carrier/period counters, segment transitions and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            cc          <= '0;
            pc          <= '0;
            cmd_q       <= '0;
            idx         <= '0;
            after_bits  <= 1'b0;
            carsel_sent <= 1'b0;
            IR_LED      <= 1'b0;
            BUSY        <= 1'b0;
            PACKET_DONE <= 1'b0;
        end else begin
            PACKET_DONE <= 1'b0;
            if (state == S_IDLE) begin
                if (SEND_PACKET) begin
                    cmd_q       <= COMMAND;
                    state       <= S_START;
                    cc          <= '0;
                    pc          <= '0;
                    idx         <= '0;
                    after_bits  <= 1'b0;
                    carsel_sent <= 1'b0;
                    BUSY        <= 1'b1;
                    IR_LED      <= BURST0;
                end else begin
                    IR_LED <= 1'b0;
                end
            end else if (cc == CC_LAST) begin
                cc <= '0;
                if (pc == seg_last) begin
                    pc <= '0;
                    case (state)
                        S_START: begin
                            state  <= S_GAP;
                            IR_LED <= 1'b0;
                        end
                        S_CARSEL: begin
                            state       <= S_GAP;
                            carsel_sent <= 1'b1;
                            IR_LED      <= 1'b0;
                        end
                        S_BIT: begin
                            state      <= S_GAP;
                            after_bits <= 1'b1;
                            IR_LED     <= 1'b0;
                        end
                        S_GAP: begin
                            if (after_bits && (idx == 2'd3)) begin
                                state       <= S_IDLE;
                                idx         <= '0;
                                after_bits  <= 1'b0;
                                carsel_sent <= 1'b0;
                                BUSY        <= 1'b0;
                                PACKET_DONE <= 1'b1;
                                IR_LED      <= 1'b0;
                            end else if (after_bits) begin
                                state      <= S_BIT;
                                idx        <= idx + 2'd1;
                                after_bits <= 1'b0;
                                IR_LED     <= BURST0;
                            end else if (carsel_sent) begin
                                state  <= S_BIT;
                                IR_LED <= BURST0;
                            end else begin
                                state  <= S_CARSEL;
                                IR_LED <= BURST0;
                            end
                        end
                        default: begin
                            state  <= S_IDLE;
                            BUSY   <= 1'b0;
                            IR_LED <= 1'b0;
                        end
                    endcase
                end else begin
                    pc     <= pc + PW'(1);
                    IR_LED <= in_burst && BURST0;
                end
            end else begin
                cc     <= cc + CW'(1);
                IR_LED <= in_burst && ((int'(cc) + 1) < CARRIER_HIGH);
            end
        end
    end

endmodule

// File: tb/tb_ir_packet_encoder.sv
// tb/tb_ir_packet_encoder.sv - scoreboard bench for ir_packet_encoder with a per-cycle reference stream
module tb_ir_packet_encoder;

    localparam int P  = 4;
    localparam int H  = 2;
    localparam int SL = 3;
    localparam int GL = 2;
    localparam int CL = 2;
    localparam int AL = 2;
    localparam int DL = 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] COMMAND = 4'h0;
    logic       SEND_PACKET = 1'b0;
    logic       IR_LED;
    logic       BUSY;
    logic       PACKET_DONE;

    ir_packet_encoder #(
        .CARRIER_PERIOD(P),
        .CARRIER_HIGH(H),
        .START_LEN(SL),
        .GAP_LEN(GL),
        .CARSEL_LEN(CL),
        .ASSERT_LEN(AL),
        .DEASSERT_LEN(DL)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .COMMAND(COMMAND),
        .SEND_PACKET(SEND_PACKET),
        .IR_LED(IR_LED),
        .BUSY(BUSY),
        .PACKET_DONE(PACKET_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic ir;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];   // expected outputs, front = the cycle now being observed
    int   len_q[$];   // expected BUSY run length per accepted packet
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_run = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Builds the whole packet from the segment list: burst segments carry the carrier.
    function automatic void push_packet(input logic [3:0] cmd);
        int segs[$];
        bit burst[$];
        int total;
        exp_t e;
        segs = {SL, GL, CL, GL};
        burst = {1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            segs.push_back(cmd[i] ? AL : DL);
            burst.push_back(1'b1);
            segs.push_back(GL);
            burst.push_back(1'b0);
        end
        total = 0;
        for (int s = 0; s < segs.size(); s++) begin
            for (int c = 0; c < segs[s] * P; c++) begin
                e.ir = burst[s] && ((c % P) < H);
                e.busy = 1'b1;
                e.done = 1'b0;
                exp_q.push_back(e);
                total++;
            end
        end
        e = '{ir: 1'b0, busy: 1'b0, done: 1'b1};
        exp_q.push_back(e);
        len_q.push_back(total);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called just after a rising edge; the request is sampled at the next edge.
    task automatic send(input logic [3:0] cmd);
        COMMAND = cmd;
        SEND_PACKET = 1'b1;
        if (exp_q.size() == 0) begin
            exp_q.push_back('0);
            push_packet(cmd);
        end else if (exp_q.size() == 1 && !exp_q[0].busy) begin
            push_packet(cmd);
        end
        step();
        SEND_PACKET = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        check("wait_done_timeout", exp_q.size(), 0);
    endtask

    // Per-cycle output monitor.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check("ir_led", int'(IR_LED), int'(e.ir));
        check("busy", int'(BUSY), int'(e.busy));
        check("packet_done", int'(PACKET_DONE), int'(e.done));
    end

    // BUSY run-length monitor.
    always @(negedge CLK) begin
        if (!RESET) begin
            busy_run = 0;
        end else if (BUSY) begin
            busy_run++;
        end else if (busy_run > 0) begin
            if (len_q.size() > 0) check("busy_length", busy_run, len_q.pop_front());
            else check("busy_length_unexpected", busy_run, 0);
            busy_run = 0;
        end
    end

    initial begin
        int d;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ir_led", int'(IR_LED), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_packet_done", int'(PACKET_DONE), 0);
        RESET = 1'b1;
        step();

        send(4'hF);
        wait_done();
        send(4'h0);
        wait_done();
        send(4'h5);
        wait_done();

        // Ignored request and command change mid-packet.
        send(4'hF);
        repeat (30) step();
        send(4'h0);
        wait_done();

        // Re-trigger in the completion cycle.
        send(4'hF);
        d = 0;
        while (exp_q.size() > 1 && d < 1000) begin
            step();
            d++;
        end
        check("retrigger_reach_done", d < 1000 ? 1 : 0, 1);
        send(4'h3);
        wait_done();

        // Asynchronous reset while the start burst is high.
        send(4'hF);
        check("pre_reset_ir_led", int'(IR_LED), 1);
        RESET = 1'b0;
        exp_q.delete();
        len_q.delete();
        #1;
        check("async_reset_ir_led", int'(IR_LED), 0);
        check("async_reset_busy", int'(BUSY), 0);
        check("async_reset_packet_done", int'(PACKET_DONE), 0);
        step();
        step();
        RESET = 1'b1;
        repeat (3) step();

        // Randomised traffic, including requests while busy.
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 4)) step();
            send(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 110)) step();
                send(4'($urandom_range(0, 15)));
            end
            wait_done();
        end

        repeat (4) step();
        check("leftover_lengths", len_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
